// File: rtl/carry_save_resolver.sv
// carry_save_resolver: resolves a carry-save pair into one WIDTH-bit sum, SEG bits per cycle; result valid WIDTH/SEG+1 cycles after accept.
// Result holds until out_ready, and a new pair may be taken in the retire cycle. Define CPA_STICKY_EN to add out_sticky.
module carry_save_resolver #(
   parameter int WIDTH       = 16,
   parameter int SEG         = 4,
   parameter int STICKY_BITS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] pp0,
   input  logic [WIDTH-1:0] pp1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
`ifdef CPA_STICKY_EN
   ,
   output logic             out_sticky
`endif
);

   localparam int NSEG = WIDTH / SEG;
   localparam int SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [SEGW-1:0] LAST_SEG = SEGW'(NSEG - 1);

   generate
      if ((WIDTH % SEG) != 0 || NSEG < 2 || STICKY_BITS < 1 || STICKY_BITS > WIDTH) begin : g_bad_cfg
         $error("carry_save_resolver: unsupported WIDTH/SEG/STICKY_BITS combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Held low through reset so in_ready only rises on the first edge after release.
   logic live;

   logic                   accept;
   logic                   last_seg;
   logic [WIDTH-1:0]       opa, opb;
   logic [WIDTH-SEG-1:0]   acc;
   logic                   carry;
   logic [SEGW-1:0]        seg;
   logic [SEG:0]           seg_sum;
   logic [WIDTH-1:0]       sum_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         live  <= 1'b0;
      end else begin
         state <= state_nxt;
         live  <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = live;
            if (in_valid && live)
               state_nxt = ADD;
         end
         ADD: begin
            if (last_seg)
               state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready)
               state_nxt = in_valid ? ADD : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept   = in_valid && in_ready;
   assign last_seg = (state == ADD) && (seg == LAST_SEG);

   // Operands shift down so the active segment always sits in the low SEG bits;
   // partial results enter acc from the top, leaving the full sum aligned at the end.
   assign seg_sum = {1'b0, opa[SEG-1:0]} + {1'b0, opb[SEG-1:0]} + {{SEG{1'b0}}, carry};
   assign sum_nxt = {seg_sum[SEG-1:0], acc};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa      <= '0;
         opb      <= '0;
         acc      <= '0;
         carry    <= 1'b0;
         seg      <= '0;
         out_sum  <= '0;
         out_cout <= 1'b0;
      end else if (accept) begin
         opa   <= pp0;
         opb   <= pp1;
         carry <= 1'b0;
         seg   <= '0;
      end else if (state == ADD) begin
         opa   <= opa >> SEG;
         opb   <= opb >> SEG;
         acc   <= sum_nxt[WIDTH-1:SEG];
         carry <= seg_sum[SEG];
         seg   <= seg + SEGW'(1);
         if (last_seg) begin
            out_sum  <= sum_nxt;
            out_cout <= seg_sum[SEG];
         end
      end
   end

`ifdef CPA_STICKY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         out_sticky <= 1'b0;
      else if (!accept && last_seg)
         out_sticky <= |sum_nxt[STICKY_BITS-1:0];
   end
`endif

endmodule

// File: tb/tb_carry_save_resolver.sv
// Bench for carry_save_resolver: directed spec cases plus randomized pairs against an arithmetic reference.
module tb_carry_save_resolver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] pp0 = '0;
   logic [15:0] pp1 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_sum;
   logic        out_cout;
`ifdef CPA_STICKY_EN
   logic        out_sticky;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   carry_save_resolver #(.WIDTH(16), .SEG(4), .STICKY_BITS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pp0       (pp0),
      .pp1       (pp1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
`ifdef CPA_STICKY_EN
      ,
      .out_sticky(out_sticky)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the full-width unsigned sum, bit 16 is the carry out.
   function automatic logic [16:0] model_add(input logic [15:0] a, input logic [15:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   // Offers one pair, waits for accept, then counts cycles (accept cycle = 1) until out_valid.
   task automatic run_one(input logic [15:0] a, input logic [15:0] b, output int lat);
      int n;
      n = 0;
      pp0 = a;
      pp1 = b;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      tick();
      in_valid = 1'b0;
      pp0 = 16'($urandom);
      pp1 = 16'($urandom);
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) tick();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      total++; if (out_sum !== 16'h0000) begin bad++; $display("FAIL reset_out_sum: got %h expected 0000", out_sum); end
      total++; if (out_cout !== 1'b0) begin bad++; $display("FAIL reset_out_cout: got %b expected 0", out_cout); end
`ifdef CPA_STICKY_EN
      total++; if (out_sticky !== 1'b0) begin bad++; $display("FAIL reset_out_sticky: got %b expected 0", out_sticky); end
`endif
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL release_in_ready_pre_edge: got %b expected 0", in_ready); end
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready_post_edge: got %b expected 1", in_ready); end
   endtask

   task automatic test_directed();
      logic [15:0] da   [4] = '{16'h00FF, 16'hFFF0, 16'hFFFF, 16'h0003};
      logic [15:0] db   [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0000};
      logic [15:0] dsum [4] = '{16'h0100, 16'hFFF1, 16'h0000, 16'h0003};
      logic        dcout[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic        dstk [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run_one(da[i], db[i], lat);
         total++; if (lat !== 5) begin bad++; $display("FAIL directed%0d_latency: got %0d expected 5", i, lat); end
         total++; if (out_sum !== dsum[i]) begin bad++; $display("FAIL directed%0d_sum: got %h expected %h", i, out_sum, dsum[i]); end
         total++; if (out_cout !== dcout[i]) begin bad++; $display("FAIL directed%0d_cout: got %b expected %b", i, out_cout, dcout[i]); end
`ifdef CPA_STICKY_EN
         total++; if (out_sticky !== dstk[i]) begin bad++; $display("FAIL directed%0d_sticky: got %b expected %b", i, out_sticky, dstk[i]); end
`else
         if (dstk[i] === 1'bx) $display("sticky table entry undefined");
`endif
         tick();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL directed%0d_valid_pulse: got %b expected 0", i, out_valid); end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] a, b;
      logic [16:0] exp;
      int lat;
      int errs;
      a = 16'($urandom);
      b = 16'($urandom);
      exp = model_add(a, b);
      out_ready = 1'b0;
      run_one(a, b, lat);
      total++; if (lat !== 5) begin bad++; $display("FAIL bp_latency: got %0d expected 5", lat); end
      errs = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid !== 1'b1 || out_sum !== exp[15:0] || in_ready !== 1'b0) errs++;
         tick();
      end
      total++; if (errs !== 0) begin bad++; $display("FAIL bp_hold: %0d stalled cycles wrong, last valid=%b sum=%h in_ready=%b, want 1/%h/0", errs, out_valid, out_sum, in_ready, exp[15:0]); end
      total++; if (out_cout !== exp[16]) begin bad++; $display("FAIL bp_cout: got %b expected %b", out_cout, exp[16]); end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_on_retire: got %b expected 1", in_ready); end
      tick();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_after_retire: got valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] qa[$];
      logic [15:0] qb[$];
      logic [16:0] qexp[$];
      int got;
      int last_cyc;
      got = 0;
      last_cyc = -1;
      for (int i = 0; i < 6; i++) begin
         qa.push_back(16'($urandom));
         qb.push_back(16'($urandom));
         qexp.push_back(model_add(qa[i], qb[i]));
      end
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               int n;
               n = 0;
               pp0 = qa[i];
               pp1 = qb[i];
               in_valid = 1'b1;
               while (!in_ready && n < 50) begin
                  tick();
                  n++;
               end
               tick();
            end
            in_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 80 && got < 6; c++) begin
               tick();
               if (out_valid) begin
                  total++; if (out_sum !== qexp[got][15:0] || out_cout !== qexp[got][16]) begin bad++; $display("FAIL b2b%0d_result: got %b_%h expected %b_%h", got, out_cout, out_sum, qexp[got][16], qexp[got][15:0]); end
                  if (got > 0) begin
                     total++; if (c - last_cyc !== 5) begin bad++; $display("FAIL b2b%0d_spacing: got %0d cycles expected 5", got, c - last_cyc); end
                  end
                  last_cyc = c;
                  got++;
               end
            end
         end
      join
      total++; if (got !== 6) begin bad++; $display("FAIL b2b_count: got %0d results expected 6", got); end
   endtask

   task automatic test_reset_mid_add();
      logic [15:0] a, b;
      logic [16:0] exp;
      int n;
      int lat;
      int highs;
      n = 0;
      out_ready = 1'b1;
      pp0 = 16'h1234;
      pp1 = 16'h0F0F;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL midrst_flags: got valid=%b in_ready=%b expected 0/0", out_valid, in_ready); end
      total++; if (out_sum !== 16'h0000 || out_cout !== 1'b0) begin bad++; $display("FAIL midrst_result: got %b_%h expected 0_0000", out_cout, out_sum); end
      tick();
      tick();
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready_pre_edge: got %b expected 0", in_ready); end
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready_post_edge: got %b expected 1", in_ready); end
      highs = 0;
      for (int c = 0; c < 6; c++) begin
         if (out_valid !== 1'b0) highs++;
         tick();
      end
      total++; if (highs !== 0) begin bad++; $display("FAIL midrst_no_valid: got %0d valid cycles expected 0", highs); end
      a = 16'($urandom);
      b = 16'($urandom);
      exp = model_add(a, b);
      run_one(a, b, lat);
      total++; if (lat !== 5) begin bad++; $display("FAIL midrst_next_latency: got %0d expected 5", lat); end
      total++; if (out_sum !== exp[15:0] || out_cout !== exp[16]) begin bad++; $display("FAIL midrst_next_result: got %b_%h expected %b_%h", out_cout, out_sum, exp[16], exp[15:0]); end
      tick();
   endtask

   task automatic test_random();
      logic [15:0] a, b;
      logic [16:0] exp;
      int lat;
      int stall;
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0:       a = 16'h0000;
            1:       a = 16'hFFFF;
            default: a = 16'($urandom);
         endcase
         b = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
         exp = model_add(a, b);
         stall = $urandom_range(0, 3);
         out_ready = (stall == 0);
         run_one(a, b, lat);
         total++; if (lat !== 5) begin bad++; $display("FAIL rnd%0d_latency: got %0d expected 5", i, lat); end
         total++; if (out_sum !== exp[15:0] || out_cout !== exp[16]) begin bad++; $display("FAIL rnd%0d_result: a=%h b=%h got %b_%h expected %b_%h", i, a, b, out_cout, out_sum, exp[16], exp[15:0]); end
`ifdef CPA_STICKY_EN
         total++; if (out_sticky !== (|exp[7:0])) begin bad++; $display("FAIL rnd%0d_sticky: got %b expected %b", i, out_sticky, |exp[7:0]); end
`endif
         if (stall > 0) begin
            repeat (stall) tick();
            total++; if (out_valid !== 1'b1 || out_sum !== exp[15:0]) begin bad++; $display("FAIL rnd%0d_stall_hold: got valid=%b sum=%h expected 1/%h", i, out_valid, out_sum, exp[15:0]); end
            out_ready = 1'b1;
         end
         tick();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd%0d_retire: got valid=%b expected 0", i, out_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_add();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
